// File: rtl/iomem_arbiter.sv
// rtl/iomem_arbiter.sv - two-master round-robin arbiter onto a shared IO-register bus
//
// Optional feature macro: IOMEM_ARBITER_TIMEOUT_EN (stalled-access timeout)
//
// Ports:
//   clk, reset                    system clock, synchronous active-high reset
//   m0_* / m1_*                   master request (valid/wstrb/addr/wdata) and
//                                 completion (ready pulse, rdata gated by ready)
//   iomem_valid/wstrb/addr/wdata  shared bus request, driven from granted master
//   iomem_ready/rdata             shared bus completion and read data
//   err_timeout                   one-cycle pulse on a force-completed access

module iomem_arbiter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        iomem_valid,
   output logic [3:0]  iomem_wstrb,
   output logic [31:0] iomem_addr,
   output logic [31:0] iomem_wdata,
   input  logic        iomem_ready,
   input  logic [31:0] iomem_rdata,
   output logic        err_timeout
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t      r_state;
   logic        r_grant;
   logic        r_last;

   logic        w_busy;
   logic        w_gvalid;
   logic        w_timeout;
   logic        w_done;
   logic [31:0] w_rdata;

   // Qualifying with reset keeps a mid-access reset from producing a ready pulse.
   assign w_busy   = (r_state == S_BUSY) && !reset;
   assign w_gvalid = r_grant ? m1_valid : m0_valid;

`ifdef IOMEM_ARBITER_TIMEOUT_EN
   logic [7:0] r_wait;

   assign w_timeout = w_busy && w_gvalid && !iomem_ready &&
                      (r_wait == 8'(TIMEOUT_CYCLES - 1));

   // Held at zero through IDLE so it starts from zero on every BUSY entry.
   always_ff @(posedge clk) begin
      if (reset || r_state == S_IDLE)
         r_wait <= '0;
      else if (!iomem_ready)
         r_wait <= r_wait + 8'd1;
   end
`else
   logic w_unused_timeout_cfg;

   assign w_timeout            = 1'b0;
   assign w_unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
`endif

   assign w_done  = w_busy && w_gvalid && (iomem_ready || w_timeout);
   assign w_rdata = w_timeout ? 32'hFFFF_FFFF : iomem_rdata;

   assign iomem_valid = w_busy && w_gvalid;
   assign iomem_wstrb = r_grant ? m1_wstrb : m0_wstrb;
   assign iomem_addr  = r_grant ? m1_addr  : m0_addr;
   assign iomem_wdata = r_grant ? m1_wdata : m0_wdata;

   assign m0_ready    = w_done && !r_grant;
   assign m1_ready    = w_done &&  r_grant;
   assign m0_rdata    = m0_ready ? w_rdata : 32'd0;
   assign m1_rdata    = m1_ready ? w_rdata : 32'd0;
   assign err_timeout = w_timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_grant <= 1'b0;
         r_last  <= 1'b1;   // m0 wins the first tie
      end else begin
         case (r_state)
            S_IDLE: begin
               if (m0_valid || m1_valid) begin
                  // On a tie, serve whichever master was not served last.
                  r_grant <= (m0_valid && m1_valid) ? ~r_last : m1_valid;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (!w_gvalid) begin
                  r_state <= S_IDLE;          // abort, last-served untouched
               end else if (w_done) begin
                  r_last  <= r_grant;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iomem_arbiter.sv
// tb/tb_iomem_arbiter.sv - directed self-checking bench for iomem_arbiter

module tb_iomem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_valid, m1_valid;
   logic        m0_ready, m1_ready;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
   logic        iomem_valid, iomem_ready, err_timeout;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   iomem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
      .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb),
      .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
      .iomem_ready(iomem_ready), .iomem_rdata(iomem_rdata),
      .err_timeout(err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m0_valid = 1'b0; m1_valid = 1'b0;
      iomem_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic seen;
      m0_wstrb = 4'h0; m1_wstrb = 4'h0;
      m0_addr = 32'h0; m1_addr = 32'h0;
      m0_wdata = 32'h0; m1_wdata = 32'h0;
      iomem_rdata = 32'h0;
      do_reset();

      // reset state
      settle();
      chk("rst_m0_ready", m0_ready, 0);
      chk("rst_m1_ready", m1_ready, 0);
      chk("rst_iomem_valid", iomem_valid, 0);
      chk("rst_err_timeout", err_timeout, 0);

      // single m0 read, zero-wait slave
      m0_valid = 1'b1; m0_addr = 32'h0300_0010; m0_wstrb = 4'h0;
      iomem_ready = 1'b1; iomem_rdata = 32'h0000_00A5;
      settle();
      chk("rd_idle_iomem_valid", iomem_valid, 0);
      chk("rd_idle_m0_ready", m0_ready, 0);
      tick(); settle();
      chk("rd_iomem_valid", iomem_valid, 1);
      chk("rd_iomem_addr", iomem_addr, 32'h0300_0010);
      chk("rd_m0_ready", m0_ready, 1);
      chk("rd_m0_rdata", m0_rdata, 32'h0000_00A5);
      chk("rd_m1_ready", m1_ready, 0);
      chk("rd_m1_rdata", m1_rdata, 0);
      m0_valid = 1'b0;
      tick(); settle();
      chk("rd_after_iomem_valid", iomem_valid, 0);
      chk("rd_after_m0_ready", m0_ready, 0);

      // continuous tie: grants alternate m0, m1, m0, m1 with IDLE gaps
      do_reset();
      m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
      m0_valid = 1'b1; m1_valid = 1'b1;
      iomem_ready = 1'b1; iomem_rdata = 32'h0000_0055;
      for (int k = 0; k < 4; k++) begin
         tick(); settle();
         chk($sformatf("rr%0d_m0_ready", k), m0_ready, (k % 2 == 0));
         chk($sformatf("rr%0d_m1_ready", k), m1_ready, (k % 2 == 1));
         chk($sformatf("rr%0d_addr", k), iomem_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
         tick(); settle();
         chk($sformatf("rr%0d_gap_valid", k), iomem_valid, 0);
      end
      m0_valid = 1'b0; m1_valid = 1'b0;

      // m1 write, slave ready after 3 wait cycles
      m1_valid = 1'b1; m1_wstrb = 4'hF; m1_addr = 32'h0300_0020;
      m1_wdata = 32'h1234_5678; iomem_ready = 1'b0; iomem_rdata = 32'hDEAD_BEEF;
      tick();
      for (int i = 1; i <= 3; i++) begin
         settle();
         chk($sformatf("wr_wait%0d_valid", i), iomem_valid, 1);
         chk($sformatf("wr_wait%0d_wdata", i), iomem_wdata, 32'h1234_5678);
         chk($sformatf("wr_wait%0d_m1_ready", i), m1_ready, 0);
         chk($sformatf("wr_wait%0d_m0_rdata", i), m0_rdata, 0);
         tick();
      end
      iomem_ready = 1'b1;
      settle();
      chk("wr_done_wstrb", iomem_wstrb, 4'hF);
      chk("wr_done_wdata", iomem_wdata, 32'h1234_5678);
      chk("wr_done_m1_ready", m1_ready, 1);
      m1_valid = 1'b0; iomem_ready = 1'b0; m1_wstrb = 4'h0;
      tick(); settle();
      chk("wr_after_m1_ready", m1_ready, 0);

      // last-served is m1, so a tie goes to m0
      m0_valid = 1'b1; m1_valid = 1'b1; iomem_ready = 1'b1;
      tick(); settle();
      chk("tie_after_wr_m0_ready", m0_ready, 1);
      chk("tie_after_wr_m1_ready", m1_ready, 0);
      m0_valid = 1'b0; m1_valid = 1'b0; iomem_ready = 1'b0;
      tick();

      // stalled m0 read: timeout on 16th BUSY cycle, or none at all
      m0_valid = 1'b1; m0_addr = 32'h0300_0030;
      tick();
      seen = 1'b0;
      for (int i = 1; i < 16; i++) begin
         settle();
         if (m0_ready || err_timeout) seen = 1'b1;
         tick();
      end
      settle();
      chk("to_early_ready", seen, 0);
`ifdef IOMEM_ARBITER_TIMEOUT_EN
      chk("to_m0_ready", m0_ready, 1);
      chk("to_err", err_timeout, 1);
      chk("to_m0_rdata", m0_rdata, 32'hFFFF_FFFF);
      m0_valid = 1'b0;
      tick(); settle();
      chk("to_after_err", err_timeout, 0);
`else
      for (int i = 16; i <= 100; i++) begin
         settle();
         if (m0_ready || err_timeout || !iomem_valid) seen = 1'b1;
         tick();
      end
      chk("noto_ready_seen", seen, 0);
      m0_valid = 1'b0;
      settle();
      chk("noto_abort_valid", iomem_valid, 0);
      tick();
`endif

      // reset in 2nd BUSY cycle of stalled m1 access
      m1_valid = 1'b1; m1_addr = 32'h0300_0040; iomem_ready = 1'b0;
      tick(); settle();
      chk("rst_mid_b1_m1_ready", m1_ready, 0);
      tick();
      reset = 1'b1;
      settle();
      chk("rst_mid_b2_m1_ready", m1_ready, 0);
      tick();
      reset = 1'b0;
      m0_valid = 1'b1; iomem_ready = 1'b1;
      settle();
      chk("rst_mid_after_valid", iomem_valid, 0);
      chk("rst_mid_after_m1_ready", m1_ready, 0);
      tick(); settle();
      chk("rst_mid_tie_m0_ready", m0_ready, 1);
      chk("rst_mid_tie_m1_ready", m1_ready, 0);
      m0_valid = 1'b0; m1_valid = 1'b0; iomem_ready = 1'b0;
      tick();

      // m0 aborts in BUSY; pending m1 is served next
      m0_valid = 1'b1;
      tick();
      m0_valid = 1'b0; m1_valid = 1'b1;
      settle();
      chk("abort_iomem_valid", iomem_valid, 0);
      chk("abort_m0_ready", m0_ready, 0);
      tick(); settle();
      chk("abort_idle_valid", iomem_valid, 0);
      tick();
      iomem_ready = 1'b1; iomem_rdata = 32'h0000_0077;
      settle();
      chk("abort_m1_addr", iomem_addr, 32'h0300_0040);
      chk("abort_m1_ready", m1_ready, 1);
      chk("abort_m1_rdata", m1_rdata, 32'h0000_0077);
      m1_valid = 1'b0; iomem_ready = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
